tl_cdc_host_arb: RTL and testbench

TL_CDC_HOST_ARB -- requirements
Module: tl_cdc_host_arb

---
 rtl/tl_cdc_host_arb.sv | 210 +++++++++++++++++++++
 tb/tb_tl_cdc_host_arb.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_cdc_host_arb.sv
// Two-host TileLink-style arbiter in front of a CDC adapter.
// Channel A beats from two hosts are round-robin arbitrated into a single
// output register stage, tagged with the host index in the source MSB.
// Channel D responses are routed back by that MSB. A per-host outstanding
// counter blocks a host once it reaches MAX_OUTST in-flight requests.
module tl_cdc_host_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = DATA_WIDTH / 8,
  parameter int HSRC_WIDTH = 1,
  parameter int MAX_OUTST  = 4
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  // Per-host Channel A
  input  logic [1:0]                h_a_valid,
  output logic [1:0]                h_a_ready,
  input  logic [5:0]                h_a_opcode,
  input  logic [5:0]                h_a_param,
  input  logic [5:0]                h_a_size,
  input  logic [2*HSRC_WIDTH-1:0]   h_a_source,
  input  logic [2*ADDR_WIDTH-1:0]   h_a_address,
  input  logic [2*MASK_WIDTH-1:0]   h_a_mask,
  input  logic [2*DATA_WIDTH-1:0]   h_a_data,
  // Merged Channel A toward the CDC adapter
  output logic                      a_valid,
  input  logic                      a_ready,
  output logic [2:0]                a_opcode,
  output logic [2:0]                a_param,
  output logic [2:0]                a_size,
  output logic [HSRC_WIDTH:0]       a_source,
  output logic [ADDR_WIDTH-1:0]     a_address,
  output logic [MASK_WIDTH-1:0]     a_mask,
  output logic [DATA_WIDTH-1:0]     a_data,
  // Channel D from the CDC adapter
  input  logic                      d_valid,
  output logic                      d_ready,
  input  logic [2:0]                d_opcode,
  input  logic [2:0]                d_param,
  input  logic [2:0]                d_size,
  input  logic [HSRC_WIDTH:0]       d_source,
  input  logic                      d_sink,
  input  logic [DATA_WIDTH-1:0]     d_data,
  input  logic                      d_error,
  // Per-host Channel D
  output logic [1:0]                h_d_valid,
  input  logic [1:0]                h_d_ready,
  output logic [2:0]                h_d_opcode,
  output logic [2:0]                h_d_param,
  output logic [2:0]                h_d_size,
  output logic [HSRC_WIDTH-1:0]     h_d_source,
  output logic                      h_d_sink,
  output logic [DATA_WIDTH-1:0]     h_d_data,
  output logic                      h_d_error,
  // Status
  output logic [5:0]                outst_cnt,
  output logic                      err_unexp_d
);

  localparam int          SRC_WIDTH = HSRC_WIDTH + 1;
  localparam logic [2:0]  LP_MAX    = 3'(MAX_OUTST);

  // Output register stage and control state
  logic                   r_a_valid;
  logic [2:0]             r_a_opcode;
  logic [2:0]             r_a_param;
  logic [2:0]             r_a_size;
  logic [SRC_WIDTH-1:0]   r_a_source;
  logic [ADDR_WIDTH-1:0]  r_a_address;
  logic [MASK_WIDTH-1:0]  r_a_mask;
  logic [DATA_WIDTH-1:0]  r_a_data;
  logic                   r_rr_ptr;
  logic [1:0][2:0]        r_cnt;
  logic                   r_err;

  logic                   w_slot_free;
  logic [1:0]             w_elig;
  logic                   w_gnt_vld;
  logic                   w_gnt_idx;
  logic                   w_accept;
  logic                   w_d_host;
  logic                   w_d_hs;
  logic [1:0]             w_inc;
  logic [1:0]             w_dec;

  // Granted host's fields
  logic [2:0]             w_sel_opcode;
  logic [2:0]             w_sel_param;
  logic [2:0]             w_sel_size;
  logic [HSRC_WIDTH-1:0]  w_sel_source;
  logic [ADDR_WIDTH-1:0]  w_sel_address;
  logic [MASK_WIDTH-1:0]  w_sel_mask;
  logic [DATA_WIDTH-1:0]  w_sel_data;

  // The register can take a beat if empty or draining this cycle.
  assign w_slot_free = !r_a_valid || a_ready;

  assign w_elig[0] = h_a_valid[0] && (r_cnt[0] < LP_MAX);
  assign w_elig[1] = h_a_valid[1] && (r_cnt[1] < LP_MAX);

  // Round-robin pick: preferred host first, then the other one.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = r_rr_ptr;
    if (w_elig[r_rr_ptr]) begin
      w_gnt_vld = 1'b1;
      w_gnt_idx = r_rr_ptr;
    end else if (w_elig[~r_rr_ptr]) begin
      w_gnt_vld = 1'b1;
      w_gnt_idx = ~r_rr_ptr;
    end
  end

  // Ready is held low while reset is asserted so nothing is accepted early.
  assign w_accept = !reset_in && w_gnt_vld && w_slot_free;

  // Ready goes only to the granted host, and only when the slot is free.
  always_comb begin
    h_a_ready = 2'b00;
    if (w_accept) h_a_ready[w_gnt_idx] = 1'b1;
  end

  assign w_sel_opcode  = w_gnt_idx ? h_a_opcode[5:3] : h_a_opcode[2:0];
  assign w_sel_param   = w_gnt_idx ? h_a_param[5:3]  : h_a_param[2:0];
  assign w_sel_size    = w_gnt_idx ? h_a_size[5:3]   : h_a_size[2:0];
  assign w_sel_source  = w_gnt_idx ? h_a_source[2*HSRC_WIDTH-1:HSRC_WIDTH]
                                   : h_a_source[HSRC_WIDTH-1:0];
  assign w_sel_address = w_gnt_idx ? h_a_address[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                   : h_a_address[ADDR_WIDTH-1:0];
  assign w_sel_mask    = w_gnt_idx ? h_a_mask[2*MASK_WIDTH-1:MASK_WIDTH]
                                   : h_a_mask[MASK_WIDTH-1:0];
  assign w_sel_data    = w_gnt_idx ? h_a_data[2*DATA_WIDTH-1:DATA_WIDTH]
                                   : h_a_data[DATA_WIDTH-1:0];

  // Load the A register on a handshake, drop valid on drain, advance rr_ptr.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_a_valid   <= 1'b0;
      r_a_opcode  <= '0;
      r_a_param   <= '0;
      r_a_size    <= '0;
      r_a_source  <= '0;
      r_a_address <= '0;
      r_a_mask    <= '0;
      r_a_data    <= '0;
      r_rr_ptr    <= 1'b0;
    end else if (w_accept) begin
      r_a_valid   <= 1'b1;
      r_a_opcode  <= w_sel_opcode;
      r_a_param   <= w_sel_param;
      r_a_size    <= w_sel_size;
      r_a_source  <= {w_gnt_idx, w_sel_source};
      r_a_address <= w_sel_address;
      r_a_mask    <= w_sel_mask;
      r_a_data    <= w_sel_data;
      r_rr_ptr    <= ~w_gnt_idx;
    end else if (a_ready) begin
      r_a_valid   <= 1'b0;
    end
  end

  assign a_valid   = r_a_valid;
  assign a_opcode  = r_a_opcode;
  assign a_param   = r_a_param;
  assign a_size    = r_a_size;
  assign a_source  = r_a_source;
  assign a_address = r_a_address;
  assign a_mask    = r_a_mask;
  assign a_data    = r_a_data;

  // D is steered purely by the host index carried in the source MSB.
  assign w_d_host   = d_source[SRC_WIDTH-1];
  assign h_d_valid  = {d_valid & w_d_host, d_valid & ~w_d_host};
  assign d_ready    = h_d_ready[w_d_host];
  assign w_d_hs     = d_valid && d_ready;

  assign h_d_opcode = d_opcode;
  assign h_d_param  = d_param;
  assign h_d_size   = d_size;
  assign h_d_source = d_source[HSRC_WIDTH-1:0];
  assign h_d_sink   = d_sink;
  assign h_d_data   = d_data;
  assign h_d_error  = d_error;

  for (genvar g = 0; g < 2; g++) begin : g_evt
    assign w_inc[g] = w_accept && (w_gnt_idx == 1'(g));
    assign w_dec[g] = w_d_hs && (w_d_host == 1'(g));
  end

  // Outstanding counters; a D with nothing outstanding flags a sticky error.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        case ({w_inc[i], w_dec[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + 3'd1;
          2'b01:   if (r_cnt[i] != 3'd0) r_cnt[i] <= r_cnt[i] - 3'd1;
          default: r_cnt[i] <= r_cnt[i];
        endcase
        if (w_dec[i] && (r_cnt[i] == 3'd0)) r_err <= 1'b1;
      end
    end
  end

  assign outst_cnt   = r_cnt;
  assign err_unexp_d = r_err;

endmodule

// File: tb/tb_tl_cdc_host_arb.sv
// Self-checking bench for tl_cdc_host_arb: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the arbiter, register stage and counters.
module tb_tl_cdc_host_arb;

  localparam int MAXO = 4;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [1:0]  h_a_valid, h_a_ready;
  logic [5:0]  h_a_opcode, h_a_param, h_a_size;
  logic [1:0]  h_a_source;
  logic [63:0] h_a_address, h_a_data;
  logic [7:0]  h_a_mask;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [1:0]  a_source;
  logic [31:0] a_address, a_data;
  logic [3:0]  a_mask;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode, d_param, d_size;
  logic [1:0]  d_source;
  logic        d_sink, d_error;
  logic [31:0] d_data;
  logic [1:0]  h_d_valid, h_d_ready;
  logic [2:0]  h_d_opcode, h_d_param, h_d_size;
  logic [0:0]  h_d_source;
  logic        h_d_sink, h_d_error;
  logic [31:0] h_d_data;
  logic [5:0]  outst_cnt;
  logic        err_unexp_d;

  always #5 clk_in = ~clk_in;

  tl_cdc_host_arb dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .h_a_valid(h_a_valid), .h_a_ready(h_a_ready),
    .h_a_opcode(h_a_opcode), .h_a_param(h_a_param), .h_a_size(h_a_size),
    .h_a_source(h_a_source), .h_a_address(h_a_address),
    .h_a_mask(h_a_mask), .h_a_data(h_a_data),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
    .d_source(d_source), .d_sink(d_sink), .d_data(d_data), .d_error(d_error),
    .h_d_valid(h_d_valid), .h_d_ready(h_d_ready),
    .h_d_opcode(h_d_opcode), .h_d_param(h_d_param), .h_d_size(h_d_size),
    .h_d_source(h_d_source), .h_d_sink(h_d_sink), .h_d_data(h_d_data),
    .h_d_error(h_d_error),
    .outst_cnt(outst_cnt), .err_unexp_d(err_unexp_d)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_av;
  logic [2:0]  m_op, m_par, m_sz;
  logic [1:0]  m_src;
  logic [31:0] m_addr, m_data;
  logic [3:0]  m_mask;
  int          m_rr;
  int          m_cnt [2];
  bit          m_err;

  task automatic m_reset();
    m_av = 0; m_op = 0; m_par = 0; m_sz = 0; m_src = 0;
    m_addr = 0; m_data = 0; m_mask = 0; m_rr = 0;
    m_cnt[0] = 0; m_cnt[1] = 0; m_err = 0;
  endtask

  // Host that would win arbitration right now, or -1.
  function automatic int m_grant();
    for (int k = 0; k < 2; k++) begin
      int h = (m_rr + k) % 2;
      if (h_a_valid[h] && m_cnt[h] < MAXO) return h;
    end
    return -1;
  endfunction

  function automatic logic [1:0] m_hready();
    int g;
    if (reset_in || (m_av && !a_ready)) return 2'b00;
    g = m_grant();
    if (g < 0) return 2'b00;
    return (g == 1) ? 2'b10 : 2'b01;
  endfunction

  // Advance the model by one clock edge using the inputs held over the cycle.
  task automatic m_step();
    logic [1:0] hr;
    int g, dh, delta;
    bit dhs;
    if (reset_in) begin m_reset(); return; end
    hr  = m_hready();
    g   = (hr == 2'b00) ? -1 : (hr[1] ? 1 : 0);
    dh  = int'(d_source[1]);
    dhs = d_valid && h_d_ready[dh];
    for (int h = 0; h < 2; h++) begin
      delta = ((g == h) ? 1 : 0) - ((dhs && dh == h) ? 1 : 0);
      if (dhs && dh == h && m_cnt[h] == 0) m_err = 1;
      m_cnt[h] = (m_cnt[h] + delta < 0) ? 0 : m_cnt[h] + delta;
    end
    if (g >= 0) begin
      m_av   = 1;
      m_op   = h_a_opcode[3*g +: 3];
      m_par  = h_a_param[3*g +: 3];
      m_sz   = h_a_size[3*g +: 3];
      m_src  = {1'(g), h_a_source[g]};
      m_addr = h_a_address[32*g +: 32];
      m_data = h_a_data[32*g +: 32];
      m_mask = h_a_mask[4*g +: 4];
      m_rr   = 1 - g;
    end else if (a_ready) begin
      m_av = 0;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_in) begin
    logic [1:0] exp_hdv;
    exp_hdv = !d_valid ? 2'b00 : (d_source[1] ? 2'b10 : 2'b01);
    chk("a_valid", 64'(a_valid), 64'(m_av));
    chk("a_address", 64'(a_address), 64'(m_addr));
    chk("a_data", 64'(a_data), 64'(m_data));
    chk("a_fields", 64'({a_opcode, a_param, a_size, a_source, a_mask}),
        64'({m_op, m_par, m_sz, m_src, m_mask}));
    chk("outst_cnt", 64'(outst_cnt), 64'({3'(m_cnt[1]), 3'(m_cnt[0])}));
    chk("err_unexp_d", 64'(err_unexp_d), 64'(m_err));
    chk("h_a_ready", 64'(h_a_ready), 64'(m_hready()));
    chk("h_d_valid", 64'(h_d_valid), 64'(exp_hdv));
    chk("d_ready", 64'(d_ready), 64'(h_d_ready[d_source[1]]));
    chk("h_d_fields", 64'({h_d_opcode, h_d_param, h_d_size, h_d_source, h_d_sink, h_d_error, h_d_data}),
        64'({d_opcode, d_param, d_size, d_source[0], d_sink, d_error, d_data}));
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
    m_step();
  endtask

  task automatic set_idle();
    h_a_valid = 2'b00; a_ready = 1'b1; d_valid = 1'b0; h_d_ready = 2'b00;
    d_source = 2'b00; h_a_source = 2'b00;
  endtask

  task automatic do_reset();
    tick();
    reset_in = 1'b1;
    m_reset();
    tick();
    tick();
    reset_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_in = 1'b1;
    m_reset();
    set_idle();
    h_a_opcode = 6'o21; h_a_param = 6'o43; h_a_size = 6'o22;
    h_a_address = 64'h0; h_a_data = {32'hBBBB_0001, 32'hAAAA_0000};
    h_a_mask = 8'hF0 | 8'h0F;
    d_opcode = 3'd1; d_param = 3'd0; d_size = 3'd2; d_sink = 1'b0;
    d_data = 32'h0; d_error = 1'b0;

    // Reset state
    tick();
    chk("rst_a_valid", 64'(a_valid), 64'(0));
    chk("rst_outst", 64'(outst_cnt), 64'(0));
    chk("rst_hready", 64'(h_a_ready), 64'(0));
    reset_in = 1'b0;

    // Both hosts streaming, no D: alternate 0,1,... until each holds 4.
    do_reset();
    set_idle();
    h_a_address = {32'h2000_0000, 32'h1000_0000};
    h_a_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("alt_valid", 64'(a_valid), 64'(1));
      chk("alt_source", 64'(a_source), (k % 2 == 1) ? 64'h2 : 64'h0);
      chk("alt_addr", 64'(a_address), (k % 2 == 1) ? 64'h2000_0000 : 64'h1000_0000);
    end
    tick();
    chk("alt_stall_valid", 64'(a_valid), 64'(0));
    chk("alt_stall_cnt", 64'(outst_cnt), 64'h24);
    chk("alt_stall_ready", 64'(h_a_ready), 64'(0));

    // Back-pressure: payload held while a_ready is low.
    do_reset();
    set_idle();
    h_a_address = {32'h0, 32'h1000_0040};
    h_a_valid = 2'b01;
    a_ready = 1'b0;
    tick();
    h_a_address = {32'h0, 32'h1000_0080};
    for (int k = 0; k < 5; k++) begin
      chk("bp_addr", 64'(a_address), 64'h1000_0040);
      chk("bp_ready", 64'(h_a_ready), 64'(0));
      tick();
    end
    a_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(h_a_ready), 64'h1);
    tick();
    chk("bp_next_addr", 64'(a_address), 64'h1000_0080);

    // Host 1 saturated, D retires one in the same cycle as an A attempt.
    do_reset();
    set_idle();
    h_a_valid = 2'b10;
    repeat (4) tick();
    chk("sat_cnt4", 64'(outst_cnt[5:3]), 64'(4));
    chk("sat_block", 64'(h_a_ready), 64'(0));
    d_valid = 1'b1; d_source = 2'b10; h_d_ready = 2'b10;
    #1;
    chk("sat_dready", 64'(d_ready), 64'(1));
    chk("sat_still_block", 64'(h_a_ready), 64'(0));
    tick();
    d_valid = 1'b0;
    #1;
    chk("sat_cnt3", 64'(outst_cnt[5:3]), 64'(3));
    chk("sat_unblock", 64'(h_a_ready), 64'h2);
    tick();
    chk("sat_cnt4_again", 64'(outst_cnt[5:3]), 64'(4));

    // D to host 1 held off by h_d_ready, then one handshake.
    h_a_valid = 2'b00;
    d_valid = 1'b1; d_source = 2'b11; d_data = 32'hDEAD_BEEF; h_d_ready = 2'b00;
    #1;
    chk("d_route_valid", 64'(h_d_valid), 64'h2);
    chk("d_route_ready", 64'(d_ready), 64'(0));
    chk("d_route_data", 64'(h_d_data), 64'hDEAD_BEEF);
    chk("d_route_src", 64'(h_d_source), 64'(1));
    tick();
    chk("d_wait_cnt", 64'(outst_cnt[5:3]), 64'(4));
    h_d_ready = 2'b10;
    tick();
    d_valid = 1'b0;
    chk("d_hs_cnt", 64'(outst_cnt[5:3]), 64'(3));
    tick();
    chk("d_hs_cnt_hold", 64'(outst_cnt[5:3]), 64'(3));

    // Unexpected D to host 0, then reset mid-burst clears everything.
    d_valid = 1'b1; d_source = 2'b00; h_d_ready = 2'b01;
    tick();
    d_valid = 1'b0;
    chk("unexp_err", 64'(err_unexp_d), 64'(1));
    chk("unexp_cnt0", 64'(outst_cnt[2:0]), 64'(0));
    h_a_valid = 2'b11; a_ready = 1'b1;
    h_a_address = {32'h2000_0010, 32'h1000_0010};
    tick();
    tick();
    reset_in = 1'b1;
    m_reset();
    #1;
    chk("mid_rst_valid", 64'(a_valid), 64'(0));
    chk("mid_rst_cnt", 64'(outst_cnt), 64'(0));
    chk("mid_rst_err", 64'(err_unexp_d), 64'(0));
    chk("mid_rst_ready", 64'(h_a_ready), 64'(0));
    chk("mid_rst_addr", 64'(a_address), 64'(0));
    tick();
    reset_in = 1'b0;
    #1;
    chk("post_rst_no_replay", 64'(a_valid), 64'(0));
    tick();
    chk("post_rst_first", 64'(a_valid), 64'(1));
    chk("post_rst_src", 64'(a_source), 64'(0));

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int dh;
      if ($urandom_range(0, 299) == 0) begin
        reset_in = 1'b1;
        m_reset();
      end else begin
        reset_in = 1'b0;
      end
      h_a_valid   = 2'($urandom_range(0, 3)) & {1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7)};
      h_a_opcode  = 6'($urandom);
      h_a_param   = 6'($urandom);
      h_a_size    = 6'($urandom);
      h_a_source  = 2'($urandom);
      h_a_address = {$urandom, $urandom};
      h_a_data    = {$urandom, $urandom};
      h_a_mask    = 8'($urandom);
      a_ready     = ($urandom_range(0, 3) != 0);
      d_valid     = ($urandom_range(0, 9) < 4);
      dh = int'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 9) begin
        if (m_cnt[dh] == 0 && m_cnt[1-dh] > 0) dh = 1 - dh;
      end
      d_source    = {1'(dh), 1'($urandom_range(0, 1))};
      h_d_ready   = {1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7)};
      d_opcode    = 3'($urandom);
      d_param     = 3'($urandom);
      d_size      = 3'($urandom);
      d_sink      = 1'($urandom);
      d_error     = 1'($urandom);
      d_data      = $urandom;
      tick();
    end

    reset_in = 1'b0;
    set_idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
